// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA result I/O blocks.
//   rsa_state_e  : serializer states (idle / streaming)
//   RSA_LEN_DEF  : default operand width in bits
//   clog2        : ceiling log2 usable in parameter expressions
package rsa_io_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rsa_state_e;

  localparam int RSA_LEN_DEF = 512;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rsa_word_serializer.sv
// Wide-to-narrow serializer for RSA result readout. Captures one DATA_LEN-bit
// operand and streams it as N_WORDS words of BUS_W bits over valid/ready.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   load, load_rdy     operand handoff (accepted when both high)
//   data_in            operand, sampled on an accepted load
//   flush              synchronous abort of the current operand
//   out_valid/ready    output handshake
//   data_out           current word (0 when out_valid is low)
//   out_last           current word is the final word of the operand
//   word_idx           transfer-order index of the current word
//   busy               a transfer is in progress
module rsa_word_serializer
  import rsa_io_pkg::*;
#(
  parameter int DATA_LEN  = RSA_LEN_DEF,
  parameter int BUS_W     = 32,
  parameter int MSB_FIRST = 0,
  localparam int N_WORDS  = DATA_LEN / BUS_W,
  localparam int IDX_W    = clog2(N_WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  output logic                load_rdy,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUS_W-1:0]    data_out,
  output logic                out_last,
  output logic [IDX_W-1:0]    word_idx,
  output logic                busy
);

  if (((DATA_LEN % BUS_W) != 0) || (N_WORDS < 2)) begin : g_bad_cfg
    $error("rsa_word_serializer: DATA_LEN must be a multiple of BUS_W with at least 2 words");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  function automatic logic [BUS_W-1:0] head_word(input logic [DATA_LEN-1:0] d);
    if (MSB_FIRST != 0) return d[DATA_LEN-1 -: BUS_W];
    else                return d[BUS_W-1:0];
  endfunction

  // Drop the word just sent; vacated bits fill with zero.
  function automatic logic [DATA_LEN-1:0] shift_word(input logic [DATA_LEN-1:0] d);
    if (MSB_FIRST != 0) return d << BUS_W;
    else                return d >> BUS_W;
  endfunction

  rsa_state_e          state_p0, state_nxt;
  logic [DATA_LEN-1:0] shreg_p0, shreg_nxt;
  logic [IDX_W-1:0]    idx_p0, idx_nxt;
  logic                vld_p0;
  logic                last_p0;
  logic                xfer;
  logic                load_acc;

  assign vld_p0   = (state_p0 == ST_STREAM);
  assign last_p0  = vld_p0 && (idx_p0 == LAST_IDX);
  assign xfer     = vld_p0 && out_ready;
  // Combinational on out_ready so a new operand can follow the last word
  // without a bubble.
  assign load_rdy = !flush && (!vld_p0 || (xfer && last_p0));
  assign load_acc = load && load_rdy;

  always_comb begin
    state_nxt = state_p0;
    shreg_nxt = shreg_p0;
    idx_nxt   = idx_p0;
    if (flush) begin
      state_nxt = ST_IDLE;
      shreg_nxt = '0;
      idx_nxt   = '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (load_acc) begin
            state_nxt = ST_STREAM;
            shreg_nxt = data_in;
            idx_nxt   = '0;
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            if (last_p0) begin
              if (load_acc) begin
                shreg_nxt = data_in;
              end else begin
                state_nxt = ST_IDLE;
                shreg_nxt = '0;
              end
              idx_nxt = '0;
            end else begin
              shreg_nxt = shift_word(shreg_p0);
              idx_nxt   = idx_p0 + IDX_W'(1);
            end
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          shreg_nxt = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // Stage p0: state, shift register and word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      shreg_p0 <= '0;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      shreg_p0 <= shreg_nxt;
      idx_p0   <= idx_nxt;
    end
  end

  assign out_valid = vld_p0;
  assign busy      = vld_p0;
  assign out_last  = last_p0;
  assign word_idx  = idx_p0;
  assign data_out  = vld_p0 ? head_word(shreg_p0) : '0;

endmodule

// File: tb/tb_rsa_word_serializer.sv
// Bench for rsa_word_serializer: two instances (LSB-first and MSB-first,
// 128-bit operand, 32-bit words) share one stimulus stream and are compared
// every cycle against an operand/index reference model.
module tb_rsa_word_serializer;

  localparam int DL = 128;
  localparam int BW = 32;
  localparam int NW = DL / BW;

  logic          clk = 1'b0;
  logic          rst_n, load, flush, out_ready;
  logic [DL-1:0] data_in;

  logic          l_rdy, l_vld, l_last, l_busy;
  logic [BW-1:0] l_data;
  logic [1:0]    l_idx;
  logic          m_rdy, m_vld, m_last, m_busy;
  logic [BW-1:0] m_data;
  logic [1:0]    m_idx_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current operand, transfer index, active flag.
  logic [DL-1:0] ref_op   = '0;
  int            ref_idx  = 0;
  bit            ref_act  = 1'b0;

  logic [31:0] lsb_q[$];
  logic [31:0] msb_q[$];
  logic [31:0] exp_q[$];

  localparam logic [DL-1:0] OP_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [DL-1:0] OP_B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  always #5 clk = ~clk;

  rsa_word_serializer #(.DATA_LEN(DL), .BUS_W(BW), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load(load), .load_rdy(l_rdy), .data_in(data_in),
    .flush(flush), .out_valid(l_vld), .out_ready(out_ready), .data_out(l_data),
    .out_last(l_last), .word_idx(l_idx), .busy(l_busy)
  );

  rsa_word_serializer #(.DATA_LEN(DL), .BUS_W(BW), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load(load), .load_rdy(m_rdy), .data_in(data_in),
    .flush(flush), .out_valid(m_vld), .out_ready(out_ready), .data_out(m_data),
    .out_last(m_last), .word_idx(m_idx_o), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input bit msb_first);
    logic [DL-1:0] t;
    if (!ref_act) return 32'h0;
    if (msb_first) t = ref_op >> (BW * (NW - 1 - ref_idx));
    else           t = ref_op >> (BW * ref_idx);
    return t[31:0];
  endfunction

  // Apply inputs for one cycle, check outputs against the model, advance.
  task automatic step(input bit ld, input logic [DL-1:0] din, input bit fl,
                      input bit rdy, input bit rn);
    bit exp_last, exp_rdy;
    load = ld; data_in = din; flush = fl; out_ready = rdy; rst_n = rn;
    #1;
    exp_last = ref_act && (ref_idx == NW - 1);
    exp_rdy  = !fl && (!ref_act || (rdy && exp_last));
    chk("lsb_valid", 128'(l_vld),  128'(ref_act));
    chk("lsb_busy",  128'(l_busy), 128'(ref_act));
    chk("lsb_last",  128'(l_last), 128'(exp_last));
    chk("lsb_idx",   128'(l_idx),  128'(ref_idx));
    chk("lsb_data",  128'(l_data), 128'(ref_word(1'b0)));
    chk("lsb_ldrdy", 128'(l_rdy),  128'(exp_rdy));
    chk("msb_valid", 128'(m_vld),  128'(ref_act));
    chk("msb_last",  128'(m_last), 128'(exp_last));
    chk("msb_idx",   128'(m_idx_o), 128'(ref_idx));
    chk("msb_data",  128'(m_data), 128'(ref_word(1'b1)));
    chk("msb_ldrdy", 128'(m_rdy),  128'(exp_rdy));
    if (rn && !fl && rdy) begin
      if (l_vld) lsb_q.push_back(l_data);
      if (m_vld) msb_q.push_back(m_data);
    end
    // Model update for this edge
    if (!rn || fl) begin
      ref_act = 1'b0; ref_idx = 0; ref_op = '0;
    end else if (!ref_act) begin
      if (ld) begin ref_act = 1'b1; ref_idx = 0; ref_op = din; end
    end else if (rdy) begin
      if (ref_idx == NW - 1) begin
        ref_idx = 0;
        if (ld) ref_op = din;
        else begin ref_act = 1'b0; ref_op = '0; end
      end else begin
        ref_idx++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_q(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
    chk({tag, "_count"}, 128'(got.size()), 128'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk({tag, "_word"}, 128'(got[i]), 128'(exp[i]));
    end
  endtask

  task automatic clear_q();
    lsb_q.delete(); msb_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; flush = 1'b0; out_ready = 1'b1; data_in = '0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);

    // Basic stream, both word orders
    clear_q();
    step(1, OP_A, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 1, 1);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    cmp_q("basic_lsb", lsb_q, exp_q);
    exp_q = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    cmp_q("basic_msb", msb_q, exp_q);

    // Backpressure while word 1 is shown
    clear_q();
    step(1, OP_A, 0, 0, 1);
    step(0, '0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0, 1);
      chk("bp_hold_data", 128'(l_data), 128'(32'h22222222));
      chk("bp_hold_idx", 128'(l_idx), 128'(1));
    end
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 1);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    cmp_q("bp_lsb", lsb_q, exp_q);

    // Back-to-back: B loaded on A's last transfer edge
    clear_q();
    step(1, OP_A, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(1, OP_B, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
              32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    cmp_q("b2b_lsb", lsb_q, exp_q);

    // Flush after word 1 with a simultaneous load
    step(1, OP_A, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(1, OP_B, 1, 1, 1);
    chk("flush_valid", 128'(l_vld), 128'(0));
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);

    // Reset mid-stream with a simultaneous load
    step(1, OP_A, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(1, OP_B, 0, 1, 0);
    chk("rst_data", 128'(l_data), 128'(0));
    step(0, '0, 0, 1, 1);

    // Load pulsed mid-stream is ignored
    clear_q();
    step(1, OP_A, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(0, '0, 0, 1, 1);
    step(1, OP_B, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 1);
    exp_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    cmp_q("ignload_lsb", lsb_q, exp_q);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0,
           {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 79) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_word_serializer.md
# rsa_word_serializer

Parametrised wide-to-narrow serializer for RSA result readout. Captures one DATA_LEN-bit operand and streams it as DATA_LEN/BUS_W words of BUS_W bits over a valid/ready channel with backpressure, selectable word order, last-word flag and flush. It sits between the RSA core result register and the host bus interface, so the core can hand off a result and return to computation immediately.

## Interface
- DATA_LEN, 512: operand width in bits. Must be an integer multiple of BUS_W; any other value fails elaboration.
- BUS_W, 32: output word width in bits.
- MSB_FIRST, 0: 0 streams the least-significant word first; 1 streams the most-significant word first.
- N_WORDS, DATA_LEN/BUS_W: derived localparam, not overridable. Must be at least 2.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- load  in  1  request to capture data_in.
- load_rdy  out  1  load is accepted when load and load_rdy are both high on the same edge.
- data_in  in  DATA_LEN  operand, sampled only on an accepted load.
- flush  in  1  synchronous abort; discards any untransferred words.
- out_valid  out  1  data_out holds a valid word.
- out_ready  in  1  consumer accepts the word.
- data_out  out  BUS_W  current word.
- out_last  out  1  data_out is word N_WORDS-1 of the operand.
- word_idx  out  $clog2(N_WORDS)  index of the current word in transfer order, starting at 0.
- busy  out  1  a transfer is in progress.

## Operation
- Two states:
  - IDLE: out_valid=0, busy=0, load_rdy=1.
  - STREAM: out_valid=1, busy=1.
- IDLE→STREAM on an accepted load. The shift register takes data_in and word_idx is set to 0.
- In STREAM:
  - A word transfers on an edge where out_valid && out_ready.
  - On each transfer the register shifts by BUS_W. The shift is toward the LSB when MSB_FIRST=0 and toward the MSB when MSB_FIRST=1. Vacated bits are zero-filled.
  - word_idx increments on each transfer.
  - data_out is data[BUS_W-1:0] when MSB_FIRST=0 and data[DATA_LEN-1:DATA_LEN-BUS_W] when MSB_FIRST=1.
- out_last = (word_idx == N_WORDS-1) && out_valid.
- A transfer with out_last high ends the operand. The block returns to IDLE, or reloads (see back-to-back).
- Backpressure: while out_valid && !out_ready, data_out, word_idx and out_last hold stable. No word is dropped or duplicated.
- Back-to-back: load_rdy = IDLE || (out_valid && out_ready && out_last). A load accepted on the final transfer edge goes straight to STREAM with the new operand at word_idx 0. out_valid does not drop.
- Flush:
  - Flush on any edge forces IDLE and clears the register and word_idx to 0.
  - Flush has priority over a simultaneous load, and that load is ignored.
  - load_rdy is masked to 0 while flush=1.
- data_out is 0 whenever out_valid=0.
- Loads presented in STREAM while load_rdy=0 are ignored; there is no queueing.
- word_idx and the transfer count never wrap past N_WORDS-1.

## Timing
- Reset (rst_n=0 at an edge) takes priority over everything, including mid-stream, and yields:
  - state IDLE, register 0, word_idx 0;
  - out_valid 0, out_last 0, busy 0, data_out 0, load_rdy 1.
- Load latency: load accepted at edge t gives out_valid=1 with word 0 from edge t+1.
- With out_ready held high, the operand drains in exactly N_WORDS cycles and out_last is high in the last of them.
- Throughput with out_ready high and back-to-back loads is one word per cycle with no bubble.
- data_out, out_valid, out_last and word_idx are registered or decoded only from registers. There is no combinational path from out_ready or load to data_out or out_valid.
- load_rdy depends combinationally on out_ready and flush. This is intentional, to allow back-to-back loads; the host must not feed load_rdy back into out_ready combinationally.

## Structure
- Shared package rsa_io_pkg holds:
  - the state enum {ST_IDLE, ST_STREAM};
  - a clog2 helper function;
  - a default-width constant RSA_LEN_DEF=512.
- Single module. The counter and shift register stay inline; no sub-module is warranted.
- The elaboration check on DATA_LEN % BUS_W and N_WORDS ≥ 2 lives in the module.

## Test plan
- Reset and basic stream, DATA_LEN=128, BUS_W=32, MSB_FIRST=0, out_ready=1:
  - Stimulus: load 0x44444444_33333333_22222222_11111111.
  - Required: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting 1 cycle after load; out_last only on 0x44444444; busy falls after that word.
- MSB_FIRST=1 with the same operand: order 0x44444444, 0x33333333, 0x22222222, 0x11111111; word_idx 0..3.
- Backpressure: drop out_ready for 3 cycles while word 1 is shown. Required: data_out stays 0x22222222 and word_idx stays 1 throughout; the full sequence is delivered exactly once.
- Back-to-back: assert load with operand B on the out_last transfer edge of operand A. Required: out_valid stays high; B word 0 appears on the next cycle; 8 words are delivered in 8 cycles.
- Flush and reset mid-stream:
  - Flush after word 1 with a simultaneous load. Required: out_valid=0 next cycle, load ignored, register 0, load_rdy=1 the following cycle.
  - Repeat with rst_n=0 instead of flush. Required: all outputs at their reset values.
- Ignored load: pulse load in STREAM at word 2. Required: stream continues unchanged and no reload occurs.
